// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet FCS checker: CRC-32 constants, FSM state
// type and the byte-wide CRC update used by the checker datapath.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Register value left behind once the FCS bytes have been folded in.
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
    localparam int unsigned FCS_LEN       = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StStream
    } fcs_state_e;

    // Non-reflected left-shift CRC-32 step; byte bit 0 enters the register first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC32_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_fcs_checker_if.sv
// Byte-stream interface of the FCS checker. The master side sources received
// bytes and observes the stripped stream and status pulses; the slave side is
// the checker. Statistics counters are present only when ETH_FCS_STATS_EN is
// defined.
interface eth_fcs_checker_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       crc_ok;
    logic       crc_err;
    logic       runt_err;
`ifdef ETH_FCS_STATS_EN
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;
`endif

    modport master (
        output in_data, in_valid, in_last,
        input  out_data, out_valid, out_last, crc_ok, crc_err, runt_err
`ifdef ETH_FCS_STATS_EN
        , input good_cnt, bad_cnt
`endif
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output out_data, out_valid, out_last, crc_ok, crc_err, runt_err
`ifdef ETH_FCS_STATS_EN
        , output good_cnt, bad_cnt
`endif
    );

endinterface

// File: rtl/eth_fcs_delay.sv
// Four-deep byte shift buffer. dout is the oldest byte, i.e. the one that
// leaves the buffer on the next shift.
module eth_fcs_delay
    import eth_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       shift_en,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] stage_q [FCS_LEN];

    // Shift one byte in per enable; clear flushes every stage to zero.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int unsigned i = 0; i < FCS_LEN; i++) begin
                stage_q[i] <= 8'h00;
            end
        end else if (shift_en) begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < FCS_LEN; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[FCS_LEN-1];

endmodule

// File: rtl/eth_fcs_checker.sv
// Ethernet FCS checker: strips the trailing 4-byte FCS from each received frame,
// checks the CRC-32 residue and flags runt frames (4 bytes or fewer).
// Optional feature macro: ETH_FCS_STATS_EN adds saturating good/bad frame counters.
module eth_fcs_checker
    import eth_pkg::*;
(
    input logic              clk,
    input logic              clear,
    eth_fcs_checker_if.slave bus
);

    localparam logic [2:0] FillFull = 3'(FCS_LEN);

    fcs_state_e  state_q;
    logic [2:0]  fill_cnt_q;
    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic [7:0]  dly_out;
    logic        stream_beat;
    logic        shift_en;

    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic        crc_ok_q;
    logic        crc_err_q;
    logic        runt_err_q;

    assign crc_next = crc32_step(crc_q, bus.in_data);

    // The fifth byte of a frame already pushes the first byte out, even though
    // the FSM only leaves FILL on that same beat.
    assign stream_beat = (state_q == StStream) ||
                         ((state_q == StFill) && (fill_cnt_q == FillFull));

    assign shift_en = bus.in_valid && !clear;

    eth_fcs_delay u_delay (
        .clk      (clk),
        .clear    (clear),
        .shift_en (shift_en),
        .din      (bus.in_data),
        .dout     (dly_out)
    );

    // Frame FSM with CRC accumulation, fill counting and registered outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= StIdle;
            fill_cnt_q  <= 3'd0;
            crc_q       <= CRC32_INIT;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            runt_err_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            runt_err_q  <= 1'b0;
            if (bus.in_valid) begin
                if (stream_beat) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= dly_out;
                end
                if (bus.in_last) begin
                    // Reinitialise so a byte in the very next cycle opens a new frame.
                    state_q    <= StIdle;
                    fill_cnt_q <= 3'd0;
                    crc_q      <= CRC32_INIT;
                    if (stream_beat) begin
                        out_last_q <= 1'b1;
                        crc_ok_q   <= (crc_next == CRC32_RESIDUE);
                        crc_err_q  <= (crc_next != CRC32_RESIDUE);
                    end else begin
                        runt_err_q <= 1'b1;
                    end
                end else begin
                    crc_q <= crc_next;
                    if (fill_cnt_q != FillFull) begin
                        fill_cnt_q <= fill_cnt_q + 3'd1;
                    end
                    unique case (state_q)
                        StIdle:   state_q <= StFill;
                        StFill:   if (stream_beat) state_q <= StStream;
                        StStream: state_q <= StStream;
                        default:  state_q <= StIdle;
                    endcase
                end
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.crc_ok    = crc_ok_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.runt_err  = runt_err_q;

`ifdef ETH_FCS_STATS_EN
    logic [31:0] good_cnt_q;
    logic [31:0] bad_cnt_q;

    // Saturating frame counters driven by the registered status pulses.
    always_ff @(posedge clk) begin
        if (clear) begin
            good_cnt_q <= 32'd0;
            bad_cnt_q  <= 32'd0;
        end else begin
            if (crc_ok_q && (good_cnt_q != 32'hFFFFFFFF)) begin
                good_cnt_q <= good_cnt_q + 32'd1;
            end
            if ((crc_err_q || runt_err_q) && (bad_cnt_q != 32'hFFFFFFFF)) begin
                bad_cnt_q <= bad_cnt_q + 32'd1;
            end
        end
    end

    assign bus.good_cnt = good_cnt_q;
    assign bus.bad_cnt  = bad_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_eth_fcs_checker.sv
// Self-checking bench for eth_fcs_checker: directed frames plus random frame
// streams compared against a frame-level reference model (reflected CRC-32).
module tb_eth_fcs_checker;

    logic clk = 1'b0;
    logic clear;

    always #5 clk = ~clk;

    eth_fcs_checker_if bus ();

    eth_fcs_checker dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Observed stream and per-cycle timing violations.
    logic [7:0] got_q[$];
    int         got_last[$];
    int         n_ok, n_bad, n_runt, n_late;

    // Expected per-cycle strobes for the current cycle / the next cycle.
    logic exp_ov = 1'b0, exp_last = 1'b0, exp_pulse = 1'b0;
    logic pend_ov = 1'b0, pend_last = 1'b0, pend_pulse = 1'b0;

    // Frames queued for the next stream.
    logic [7:0] stim[$];
    int         lens[$];
    int         exp_good = 0;
    int         exp_bad  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample outputs half a cycle away from the active edge.
    always @(negedge clk) begin
        if (bus.out_valid !== exp_ov) n_late++;
        if (bus.out_last !== exp_last) n_late++;
        if ((bus.crc_ok | bus.crc_err | bus.runt_err) !== exp_pulse) n_late++;
        if (int'(bus.crc_ok) + int'(bus.crc_err) + int'(bus.runt_err) > 1) n_late++;
        if (bus.out_valid === 1'b1) begin
            got_q.push_back(bus.out_data);
            if (bus.out_last === 1'b1) got_last.push_back(got_q.size() - 1);
        end
        if (bus.crc_ok === 1'b1) n_ok++;
        if (bus.crc_err === 1'b1) n_bad++;
        if (bus.runt_err === 1'b1) n_runt++;
    end

    // Standard Ethernet CRC-32 (reflected, final inversion) over q[pos +: len].
    function automatic logic [31:0] ref_crc(input logic [7:0] q[$], input int pos, input int len);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int k = 0; k < len; k++) begin
            c ^= {24'h0, q[pos+k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        exp_ov     = pend_ov;
        exp_last   = pend_last;
        exp_pulse  = pend_pulse;
        pend_ov    = 1'b0;
        pend_last  = 1'b0;
        pend_pulse = 1'b0;
    endtask

    task automatic clear_acc();
        got_q.delete();
        got_last.delete();
        n_ok = 0; n_bad = 0; n_runt = 0; n_late = 0;
    endtask

    task automatic add_frame(input logic [7:0] f[$]);
        foreach (f[i]) stim.push_back(f[i]);
        lens.push_back(f.size());
    endtask

    // Good frame: random payload followed by its FCS, least significant byte first.
    task automatic add_good(input int plen);
        logic [7:0] f[$];
        logic [31:0] c;
        for (int i = 0; i < plen; i++) f.push_back(8'($urandom));
        c = ref_crc(f, 0, plen);
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
        add_frame(f);
    endtask

    task automatic send_stream(input int gap, input bit rnd_gap);
        int pos = 0;
        int g;
        foreach (lens[k]) begin
            for (int i = 0; i < lens[k]; i++) begin
                bus.in_data  = stim[pos+i];
                bus.in_valid = 1'b1;
                bus.in_last  = (i == lens[k] - 1);
                pend_ov      = (i >= 4);
                pend_last    = (i == lens[k] - 1) && (lens[k] >= 5);
                pend_pulse   = (i == lens[k] - 1);
                tick();
                bus.in_valid = 1'b0;
                bus.in_last  = 1'($urandom);
                bus.in_data  = 8'($urandom);
                if (i != lens[k] - 1) begin
                    g = rnd_gap ? int'($urandom_range(0, 2)) : gap;
                    repeat (g) tick();
                end
            end
            pos += lens[k];
        end
        bus.in_last = 1'b0;
        repeat (2) tick();
    endtask

    task automatic check_stream(input string tag);
        logic [7:0] exp_bytes[$];
        int exp_lidx[$];
        int e_ok = 0, e_bad = 0, e_runt = 0;
        int pos = 0;
        int n;
        logic [31:0] c;
        foreach (lens[k]) begin
            n = lens[k];
            if (n <= 4) begin
                e_runt++;
                exp_bad++;
            end else begin
                for (int j = 0; j < n - 4; j++) exp_bytes.push_back(stim[pos+j]);
                exp_lidx.push_back(exp_bytes.size() - 1);
                c = ref_crc(stim, pos, n - 4);
                if ({stim[pos+n-1], stim[pos+n-2], stim[pos+n-3], stim[pos+n-4]} == c) begin
                    e_ok++;
                    exp_good++;
                end else begin
                    e_bad++;
                    exp_bad++;
                end
            end
            pos += n;
        end
        check_eq({tag, " nbytes"}, got_q.size(), exp_bytes.size());
        for (int j = 0; j < exp_bytes.size() && j < got_q.size(); j++)
            check_eq($sformatf("%s byte%0d", tag, j), got_q[j], exp_bytes[j]);
        check_eq({tag, " nlast"}, got_last.size(), exp_lidx.size());
        for (int j = 0; j < exp_lidx.size() && j < got_last.size(); j++)
            check_eq($sformatf("%s last%0d", tag, j), got_last[j], exp_lidx[j]);
        check_eq({tag, " crc_ok"}, n_ok, e_ok);
        check_eq({tag, " crc_err"}, n_bad, e_bad);
        check_eq({tag, " runt_err"}, n_runt, e_runt);
        check_eq({tag, " timing"}, n_late, 0);
        stim.delete();
        lens.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " out_valid"}, bus.out_valid, 0);
        check_eq({tag, " out_data"}, bus.out_data, 0);
        check_eq({tag, " out_last"}, bus.out_last, 0);
        check_eq({tag, " status"}, {bus.crc_ok, bus.crc_err, bus.runt_err}, 0);
`ifdef ETH_FCS_STATS_EN
        check_eq({tag, " good_cnt"}, bus.good_cnt, 0);
        check_eq({tag, " bad_cnt"}, bus.bad_cnt, 0);
`endif
    endtask

    task automatic do_clear();
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        clear        = 1'b1;
        tick();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        exp_good     = 0;
        exp_bad      = 0;
    endtask

    logic [7:0] ref_frame[$];
    logic [7:0] tmp[$];

    initial begin
        clear        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) tick();
        clear = 1'b0;
        check_idle_outputs("reset");

        ref_frame = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                      8'h26, 8'h39, 8'hF4, 8'hCB};

        // Known-good frame.
        clear_acc(); add_frame(ref_frame); send_stream(0, 1'b0); check_stream("good");
        // Corrupted final FCS byte.
        tmp = ref_frame; tmp[12] = 8'hCA;
        clear_acc(); add_frame(tmp); send_stream(0, 1'b0); check_stream("bad");
        // Runt.
        tmp = '{8'hAA, 8'hBB, 8'hCC};
        clear_acc(); add_frame(tmp); send_stream(0, 1'b0); check_stream("runt");
`ifdef ETH_FCS_STATS_EN
        check_eq("stats good_cnt", bus.good_cnt, 1);
        check_eq("stats bad_cnt", bus.bad_cnt, 2);
`endif
        // Gapped frames followed back-to-back.
        clear_acc(); add_frame(ref_frame); add_frame(ref_frame);
        send_stream(2, 1'b0); check_stream("gapped");

        // Abort after six bytes, then a full frame.
        clear_acc();
        for (int i = 0; i < 6; i++) begin
            bus.in_data = ref_frame[i]; bus.in_valid = 1'b1; bus.in_last = 1'b0;
            pend_ov = (i >= 4);
            tick();
            bus.in_valid = 1'b0;
        end
        do_clear();
        check_idle_outputs("clear");
        tick();
        check_eq("abort nbytes", got_q.size(), 2);
        check_eq("abort status", n_ok + n_bad + n_runt, 0);
        check_eq("abort timing", n_late, 0);
        clear_acc(); add_frame(ref_frame); send_stream(0, 1'b0); check_stream("after_clear");

        // Length boundaries 4 and 5, back-to-back.
        clear_acc();
        tmp = '{8'h01, 8'h02, 8'h03, 8'h04};
        add_frame(tmp);
        add_good(1);
        tmp = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
        add_frame(tmp);
        add_good(0);
        send_stream(0, 1'b0); check_stream("bounds");

        // Random streams of good, corrupted and random frames with random gaps.
        for (int s = 0; s < 12; s++) begin
            clear_acc();
            for (int f = 0; f < 3; f++) begin
                case ($urandom_range(0, 2))
                    0: add_good(int'($urandom_range(1, 16)));
                    1: begin
                        add_good(int'($urandom_range(1, 16)));
                        stim[stim.size() - 1 - int'($urandom_range(0, 3))] ^= 8'h10;
                    end
                    default: begin
                        tmp.delete();
                        repeat ($urandom_range(1, 20)) tmp.push_back(8'($urandom));
                        add_frame(tmp);
                    end
                endcase
            end
            send_stream(0, 1'b1);
            check_stream($sformatf("rnd%0d", s));
        end

`ifdef ETH_FCS_STATS_EN
        check_eq("final good_cnt", bus.good_cnt, exp_good);
        check_eq("final bad_cnt", bus.bad_cnt, exp_bad);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
